// File: rtl/datamover_pkg.sv
// Shared DataMover definitions: the 72-bit command layout, status bit positions,
// the S2MM writer state encoding and small field helpers.
package datamover_pkg;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] saddr;
    logic        drr;
    logic        eof;
    logic [5:0]  dsa;
    logic        incr;
    logic [22:0] btt;
  } dm_cmd_t;

  localparam logic CMD_INCR = 1'b1;
  localparam logic CMD_EOF  = 1'b1;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;
  localparam int STS_TAG_HI = 3;
  localparam int STS_TAG_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_STS  = 3'd3,
    ST_DONE = 3'd4
  } dm_state_e;

  // Byte-enable mask for the final beat of a burst of len bytes.
  function automatic logic [7:0] last_keep(input logic [2:0] len);
    logic [7:0] keep;
    if (len == 3'd0) begin
      keep = 8'hFF;
    end else begin
      keep = (8'h01 << len) - 8'h01;
    end
    return keep;
  endfunction

  function automatic logic sts_error(input logic [7:0] sts, input logic [3:0] tag);
    return (sts[STS_TAG_HI:STS_TAG_LO] != tag) || !sts[STS_OKAY] ||
           sts[STS_SLVERR] || sts[STS_DECERR] || sts[STS_INTERR];
  endfunction

endpackage

// File: rtl/datamover_s2mm_writer_if.sv
// Requester, command, data and status streams of the S2MM write front end.
interface datamover_s2mm_writer_if;
  logic        i_wr_cmd_req;
  logic [31:0] i_wr_cmd_addr;
  logic [22:0] i_wr_cmd_length;
  logic        o_wr_cmd_ack;
  logic        i_wr_data_valid;
  logic [63:0] i_wr_data;
  logic        o_wr_data_ready;
  logic        o_wr_data_finish;
  logic        o_wr_err;
  logic [7:0]  o_wr_sts;
  logic        o_busy;
  logic        o_s2mm_wr_cmd_tvalid;
  logic        i_s2mm_wr_cmd_tready;
  logic [71:0] o_s2mm_wr_cmd_tdata;
  logic [63:0] o_s2mm_wr_tdata;
  logic [7:0]  o_s2mm_wr_tkeep;
  logic        o_s2mm_wr_tlast;
  logic        o_s2mm_wr_tvalid;
  logic        i_s2mm_wr_tready;
  logic        i_s2mm_sts_tvalid;
  logic [7:0]  i_s2mm_sts_tdata;
  logic        i_s2mm_sts_tkeep;
  logic        i_s2mm_sts_tlast;
  logic        o_s2mm_sts_tready;

  modport slave (
    input  i_wr_cmd_req, i_wr_cmd_addr, i_wr_cmd_length, i_wr_data_valid, i_wr_data,
           i_s2mm_wr_cmd_tready, i_s2mm_wr_tready, i_s2mm_sts_tvalid, i_s2mm_sts_tdata,
           i_s2mm_sts_tkeep, i_s2mm_sts_tlast,
    output o_wr_cmd_ack, o_wr_data_ready, o_wr_data_finish, o_wr_err, o_wr_sts, o_busy,
           o_s2mm_wr_cmd_tvalid, o_s2mm_wr_cmd_tdata, o_s2mm_wr_tdata, o_s2mm_wr_tkeep,
           o_s2mm_wr_tlast, o_s2mm_wr_tvalid, o_s2mm_sts_tready
  );

  modport master (
    output i_wr_cmd_req, i_wr_cmd_addr, i_wr_cmd_length, i_wr_data_valid, i_wr_data,
           i_s2mm_wr_cmd_tready, i_s2mm_wr_tready, i_s2mm_sts_tvalid, i_s2mm_sts_tdata,
           i_s2mm_sts_tkeep, i_s2mm_sts_tlast,
    input  o_wr_cmd_ack, o_wr_data_ready, o_wr_data_finish, o_wr_err, o_wr_sts, o_busy,
           o_s2mm_wr_cmd_tvalid, o_s2mm_wr_cmd_tdata, o_s2mm_wr_tdata, o_s2mm_wr_tkeep,
           o_s2mm_wr_tlast, o_s2mm_wr_tvalid, o_s2mm_sts_tready
  );
endinterface

// File: rtl/datamover_s2mm_writer.sv
// S2MM write front end: validates a request, issues one DataMover command,
// passes the data burst through with tkeep/tlast and checks the returned status.
module datamover_s2mm_writer
  import datamover_pkg::*;
#(
  parameter int STS_TIMEOUT = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  datamover_s2mm_writer_if.slave         bus
);

  localparam int TMO_W = (STS_TIMEOUT > 2) ? $clog2(STS_TIMEOUT) : 1;

  dm_state_e   r_state;
  dm_state_e   w_next;
  logic [31:0] r_addr;
  logic [22:0] r_len;
  logic [3:0]  r_tag;
  logic [3:0]  r_cmd_tag;
  logic [20:0] r_beats;
  logic [TMO_W-1:0] r_tmo;
  logic        r_err;
  logic [7:0]  r_sts;
  logic        r_ack;

  logic        w_req_ok;
  logic [23:0] w_len_p7;
  logic        w_last;
  logic        w_beat_hs;
  logic        w_tmo_hit;
  dm_cmd_t     w_cmd;

  assign w_req_ok  = (bus.i_wr_cmd_length != 23'd0) && (bus.i_wr_cmd_addr[2:0] == 3'd0);
  assign w_len_p7  = {1'b0, bus.i_wr_cmd_length} + 24'd7;
  assign w_last    = (r_beats == 21'd1);
  assign w_beat_hs = (r_state == ST_DATA) && bus.i_wr_data_valid && bus.i_s2mm_wr_tready;
  assign w_tmo_hit = (r_tmo == TMO_W'(STS_TIMEOUT - 1));

  always_comb begin
    w_cmd       = '0;
    w_cmd.btt   = r_len;
    w_cmd.incr  = CMD_INCR;
    w_cmd.eof   = CMD_EOF;
    w_cmd.saddr = r_addr;
    w_cmd.tag   = r_tag;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_wr_cmd_req) begin
          w_next = w_req_ok ? ST_CMD : ST_DONE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (bus.i_s2mm_wr_cmd_tready) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_CMD;
        end
      end
      ST_DATA: begin
        if (w_beat_hs && w_last) begin
          w_next = ST_STS;
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_STS: begin
        if (bus.i_s2mm_sts_tvalid || w_tmo_hit) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_STS;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, tag, beat and timeout counters, completion status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= 32'd0;
      r_len     <= 23'd0;
      r_tag     <= 4'd0;
      r_cmd_tag <= 4'd0;
      r_beats   <= 21'd0;
      r_tmo     <= '0;
      r_err     <= 1'b0;
      r_sts     <= 8'h00;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_state != ST_STS) begin
        r_tmo <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.i_wr_cmd_req) begin
            r_ack   <= 1'b1;
            r_addr  <= bus.i_wr_cmd_addr;
            r_len   <= bus.i_wr_cmd_length;
            r_beats <= w_len_p7[23:3];
            if (!w_req_ok) begin
              r_err <= 1'b1;
              r_sts <= 8'h00;
            end
          end
        end
        ST_CMD: begin
          if (bus.i_s2mm_wr_cmd_tready) begin
            r_cmd_tag <= r_tag;
            r_tag     <= r_tag + 4'd1;
          end
        end
        ST_DATA: begin
          if (w_beat_hs) begin
            r_beats <= r_beats - 21'd1;
          end
        end
        ST_STS: begin
          if (bus.i_s2mm_sts_tvalid) begin
            r_sts <= bus.i_s2mm_sts_tdata;
            r_err <= sts_error(bus.i_s2mm_sts_tdata, r_cmd_tag);
          end else if (w_tmo_hit) begin
            r_sts <= 8'h00;
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_DONE: r_err <= r_err;
        default: r_err <= r_err;
      endcase
    end
  end

  // Output decode; the data path is a pure pass-through gated by the DATA state.
  always_comb begin
    bus.o_wr_cmd_ack         = r_ack;
    bus.o_busy               = (r_state != ST_IDLE);
    bus.o_wr_data_finish     = (r_state == ST_DONE);
    bus.o_wr_err             = (r_state == ST_DONE) && r_err;
    bus.o_wr_sts             = r_sts;
    bus.o_s2mm_wr_cmd_tvalid = (r_state == ST_CMD);
    bus.o_s2mm_sts_tready    = (r_state == ST_STS);
    bus.o_s2mm_wr_cmd_tdata  = 72'd0;
    bus.o_s2mm_wr_tdata      = 64'd0;
    bus.o_s2mm_wr_tvalid     = 1'b0;
    bus.o_wr_data_ready      = 1'b0;
    bus.o_s2mm_wr_tlast      = 1'b0;
    bus.o_s2mm_wr_tkeep      = 8'h00;
    if (r_state == ST_CMD) begin
      bus.o_s2mm_wr_cmd_tdata = w_cmd;
    end else begin
      bus.o_s2mm_wr_cmd_tdata = 72'd0;
    end
    if (r_state == ST_DATA) begin
      bus.o_s2mm_wr_tdata  = bus.i_wr_data;
      bus.o_s2mm_wr_tvalid = bus.i_wr_data_valid;
      bus.o_wr_data_ready  = bus.i_s2mm_wr_tready;
      bus.o_s2mm_wr_tlast  = w_last;
      bus.o_s2mm_wr_tkeep  = w_last ? last_keep(r_len[2:0]) : 8'hFF;
    end else begin
      bus.o_s2mm_wr_tlast  = 1'b0;
    end
  end

endmodule

// File: tb/tb_datamover_s2mm_writer.sv
// Directed bench for datamover_s2mm_writer: a transaction table plus hand-written
// backpressure, status-timeout and mid-burst reset sequences.
module tb_datamover_s2mm_writer;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  datamover_s2mm_writer_if bus ();

  datamover_s2mm_writer #(.STS_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [22:0] len;
    logic [7:0]  sts;
    bit          rej;
    int          beats;
    logic [7:0]  keep;
    logic [3:0]  tag;
    logic        exp_err;
    logic [7:0]  exp_sts;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int b);
    return {8'hD0, 24'(b), 32'h1234_5678 ^ 32'(b)};
  endfunction

  task automatic request(input logic [31:0] a, input logic [22:0] l);
    bit got_ack;
    got_ack = 1'b0;
    bus.i_wr_cmd_req    = 1'b1;
    bus.i_wr_cmd_addr   = a;
    bus.i_wr_cmd_length = l;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      step();
      if (bus.o_wr_cmd_ack) got_ack = 1'b1;
    end
    bus.i_wr_cmd_req = 1'b0;
    check("ack", 72'(got_ack), 72'd1);
  endtask

  task automatic cmd_phase(input logic [3:0] tag, input logic [31:0] a, input logic [22:0] l);
    logic [71:0] exp;
    exp = {4'h0, tag, a, 1'b0, 1'b1, 6'h00, 1'b1, l};
    check("cmd_tvalid", 72'(bus.o_s2mm_wr_cmd_tvalid), 72'd1);
    check("cmd_tdata", bus.o_s2mm_wr_cmd_tdata, exp);
    bus.i_wr_data_valid  = 1'b1;
    bus.i_s2mm_wr_tready = 1'b1;
    #1;
    check("no_data_in_cmd", {70'd0, bus.o_wr_data_ready, bus.o_s2mm_wr_tvalid}, 72'd0);
    step();
    check("cmd_hold", {bus.o_s2mm_wr_cmd_tvalid, bus.o_s2mm_wr_cmd_tdata}, {1'b1, exp});
    bus.i_wr_data_valid      = 1'b0;
    bus.i_s2mm_wr_tready     = 1'b0;
    bus.i_s2mm_wr_cmd_tready = 1'b1;
    step();
    bus.i_s2mm_wr_cmd_tready = 1'b0;
    check("cmd_dropped", 72'(bus.o_s2mm_wr_cmd_tvalid), 72'd0);
  endtask

  task automatic data_phase(input int n, input logic [7:0] lk);
    int bad;
    logic [7:0] ek;
    bad = 0;
    for (int b = 0; b < n; b++) begin
      bus.i_wr_data        = beat_data(b);
      bus.i_wr_data_valid  = 1'b1;
      bus.i_s2mm_wr_tready = 1'b1;
      #1;
      ek = (b == n - 1) ? lk : 8'hFF;
      if (bus.o_s2mm_wr_tdata !== beat_data(b) || bus.o_s2mm_wr_tvalid !== 1'b1 ||
          bus.o_wr_data_ready !== 1'b1 || bus.o_s2mm_wr_tkeep !== ek ||
          bus.o_s2mm_wr_tlast !== (b == n - 1)) bad++;
      step();
    end
    bus.i_wr_data_valid  = 1'b0;
    bus.i_s2mm_wr_tready = 1'b0;
    check("beat_errors", 72'(bad), 72'd0);
    check("sts_tready", 72'(bus.o_s2mm_sts_tready), 72'd1);
  endtask

  task automatic status_phase(input logic [7:0] s, input logic exp_err, input logic [7:0] exp_sts);
    bus.i_s2mm_sts_tvalid = 1'b1;
    bus.i_s2mm_sts_tdata  = s;
    bus.i_s2mm_sts_tkeep  = 1'b1;
    bus.i_s2mm_sts_tlast  = 1'b1;
    step();
    bus.i_s2mm_sts_tvalid = 1'b0;
    check("finish", {bus.o_wr_data_finish, bus.o_wr_err, bus.o_wr_sts}, {1'b1, exp_err, exp_sts});
    step();
    check("after_finish", {bus.o_wr_data_finish, bus.o_busy, bus.o_wr_sts}, {2'b00, exp_sts});
  endtask

  initial begin
    int idx;
    int cyc;
    int bad;
    bit v;
    bit r;

    bus.i_wr_cmd_req = 1'b0;       bus.i_wr_cmd_addr = 32'd0;  bus.i_wr_cmd_length = 23'd0;
    bus.i_wr_data_valid = 1'b0;    bus.i_wr_data = 64'd0;      bus.i_s2mm_wr_cmd_tready = 1'b0;
    bus.i_s2mm_wr_tready = 1'b0;   bus.i_s2mm_sts_tvalid = 1'b0;
    bus.i_s2mm_sts_tdata = 8'h00;  bus.i_s2mm_sts_tkeep = 1'b0; bus.i_s2mm_sts_tlast = 1'b0;

    vecs[0] = '{32'h0000_0000, 23'd2048, 8'h80, 1'b0, 256, 8'hFF, 4'd0, 1'b0, 8'h80};
    vecs[1] = '{32'h0000_1000, 23'd2035, 8'h80, 1'b0, 255, 8'h07, 4'd1, 1'b1, 8'h80};
    vecs[2] = '{32'h0000_0000, 23'd0,    8'h00, 1'b1, 0,   8'h00, 4'd2, 1'b1, 8'h00};
    vecs[3] = '{32'h0000_0004, 23'd16,   8'h00, 1'b1, 0,   8'h00, 4'd2, 1'b1, 8'h00};
    vecs[4] = '{32'h0000_2000, 23'd5,    8'h82, 1'b0, 1,   8'h1F, 4'd2, 1'b0, 8'h82};
    vecs[5] = '{32'h0000_0008, 23'd9,    8'hC3, 1'b0, 2,   8'h01, 4'd3, 1'b1, 8'hC3};
    vecs[6] = '{32'h0000_0010, 23'd8,    8'h04, 1'b0, 1,   8'hFF, 4'd4, 1'b1, 8'h04};

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_tdata", bus.o_s2mm_wr_cmd_tdata, 72'd0);
    check("rst_ctl", {bus.o_wr_cmd_ack, bus.o_s2mm_wr_cmd_tvalid, bus.o_s2mm_wr_tvalid,
                      bus.o_wr_data_ready, bus.o_s2mm_wr_tlast, bus.o_s2mm_wr_tkeep,
                      bus.o_wr_data_finish, bus.o_wr_err, bus.o_wr_sts, bus.o_busy,
                      bus.o_s2mm_sts_tready}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[k]) begin
      request(vecs[k].addr, vecs[k].len);
      if (vecs[k].rej) begin
        check("reject_finish", {bus.o_wr_data_finish, bus.o_wr_err, bus.o_wr_sts,
                                bus.o_s2mm_wr_cmd_tvalid}, {1'b1, 1'b1, 8'h00, 1'b0});
        step();
        check("reject_idle", {bus.o_wr_data_finish, bus.o_busy, bus.o_s2mm_wr_cmd_tvalid}, 72'd0);
      end else begin
        cmd_phase(vecs[k].tag, vecs[k].addr, vecs[k].len);
        data_phase(vecs[k].beats, vecs[k].keep);
        status_phase(vecs[k].sts, vecs[k].exp_err, vecs[k].exp_sts);
      end
    end

    // Backpressure from both sides on a 3-beat burst.
    request(32'h0000_0100, 23'd24);
    cmd_phase(4'd5, 32'h0000_0100, 23'd24);
    idx = 0;
    bad = 0;
    for (cyc = 0; idx < 3 && cyc < 300; cyc++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      bus.i_wr_data_valid  = v;
      bus.i_s2mm_wr_tready = r;
      bus.i_wr_data        = beat_data(idx);
      #1;
      if (bus.o_s2mm_wr_tvalid !== v || bus.o_wr_data_ready !== r ||
          bus.o_s2mm_wr_tlast !== (idx == 2)) bad++;
      if (v && r) begin
        if (bus.o_s2mm_wr_tdata !== beat_data(idx) || bus.o_s2mm_wr_tkeep !== 8'hFF) bad++;
        idx++;
      end
      step();
    end
    bus.i_wr_data_valid  = 1'b0;
    bus.i_s2mm_wr_tready = 1'b0;
    check("bp_beats", 72'(idx), 72'd3);
    check("bp_errors", 72'(bad), 72'd0);
    check("bp_sts_state", 72'(bus.o_s2mm_sts_tready), 72'd1);
    status_phase(8'h85, 1'b0, 8'h85);

    // No status returned: error after STS_TIMEOUT cycles.
    request(32'h0000_0080, 23'd8);
    cmd_phase(4'd6, 32'h0000_0080, 23'd8);
    data_phase(1, 8'hFF);
    for (cyc = 0; cyc < 100 && !bus.o_wr_data_finish; cyc++) step();
    check("tmo_cycles", 72'(cyc), 72'(TMO));
    check("tmo_finish", {bus.o_wr_data_finish, bus.o_wr_err, bus.o_wr_sts}, {1'b1, 1'b1, 8'h00});
    step();
    check("tmo_idle", {bus.o_wr_data_finish, bus.o_busy}, 72'd0);

    // Reset in the middle of a 32-beat burst.
    request(32'h0000_0200, 23'd256);
    cmd_phase(4'd7, 32'h0000_0200, 23'd256);
    for (int b = 0; b < 5; b++) begin
      bus.i_wr_data        = beat_data(b);
      bus.i_wr_data_valid  = 1'b1;
      bus.i_s2mm_wr_tready = 1'b1;
      step();
    end
    check("mid_still_data", {bus.o_busy, bus.o_s2mm_wr_tvalid, bus.o_s2mm_wr_tlast}, {1'b1, 1'b1, 1'b0});
    rst_n = 1'b0;
    #2;
    check("mid_rst_ctl", {bus.o_wr_cmd_ack, bus.o_s2mm_wr_cmd_tvalid, bus.o_s2mm_wr_tvalid,
                          bus.o_wr_data_ready, bus.o_s2mm_wr_tlast, bus.o_s2mm_wr_tkeep,
                          bus.o_wr_data_finish, bus.o_wr_err, bus.o_wr_sts, bus.o_busy,
                          bus.o_s2mm_sts_tready}, 72'd0);
    check("mid_rst_tdata", 72'(bus.o_s2mm_wr_tdata), 72'd0);
    bus.i_wr_data_valid  = 1'b0;
    bus.i_s2mm_wr_tready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    request(32'h0000_0040, 23'd8);
    cmd_phase(4'd0, 32'h0000_0040, 23'd8);
    data_phase(1, 8'hFF);
    status_phase(8'h80, 1'b0, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datamover_s2mm_writer.md
# datamover_s2mm_writer

Write-side front end for the AXI DataMover S2MM channel. Accepts a byte-addressed write request and its 64-bit data stream from user logic. Issues the 72-bit S2MM command and streams the data with correct `tkeep`/`tlast`. Consumes the S2MM status word and reports completion or error back to the requester; sits directly upstream of the DataMover that writes the HP0 port.

## Interface
- `STS_TIMEOUT`, 4096: cycles to wait for S2MM status before declaring an error; must be ≥ 2.
- `clk` in 1: single clock for all ports.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_wr_cmd_req` in 1: level request; held with address and length until `o_wr_cmd_ack`.
- `i_wr_cmd_addr` in 32: byte start address; bits [2:0] must be 0.
- `i_wr_cmd_length` in 23: bytes to transfer (BTT); must be nonzero.
- `o_wr_cmd_ack` out 1: one-cycle pulse, request accepted or rejected.
- `i_wr_data_valid`, `i_wr_data[63:0]` in: user data beat.
- `o_wr_data_ready` out 1: beat consumed when high together with valid.
- `o_wr_data_finish` out 1: one-cycle completion pulse.
- `o_wr_err` out 1: qualified by `o_wr_data_finish`.
- `o_wr_sts` out 8: last status word, held until the next finish.
- `o_busy` out 1: state is not IDLE.
- `o_s2mm_wr_cmd_tvalid` out 1, `i_s2mm_wr_cmd_tready` in 1, `o_s2mm_wr_cmd_tdata` out 72: command stream.
- `o_s2mm_wr_tdata` out 64, `o_s2mm_wr_tkeep` out 8, `o_s2mm_wr_tlast` out 1, `o_s2mm_wr_tvalid` out 1, `i_s2mm_wr_tready` in 1: data stream.
- `i_s2mm_sts_tvalid` in 1, `i_s2mm_sts_tdata` in 8, `i_s2mm_sts_tkeep` in 1, `i_s2mm_sts_tlast` in 1, `o_s2mm_sts_tready` out 1: status stream.

## Operation
- FSM states: IDLE, CMD, DATA, STS, DONE.
- **IDLE**
  - On `i_wr_cmd_req` with a valid request: latch address and length, then go to CMD.
  - On `i_wr_cmd_req` with zero length or misaligned address: go to DONE with the error flag set and `o_wr_sts` = 8'h00. No command is issued.
- **Command word**
  - [22:0] BTT = length.
  - [23] = 1 (INCR).
  - [29:24] = 0.
  - [30] EOF = 1.
  - [31] DRR = 0.
  - [63:32] = address.
  - [67:64] = tag.
  - [71:68] = 0.
- **Tag:** 4-bit counter, reset 0. Increments on each command handshake and wraps 15→0.
- **CMD:** `tvalid` held high with stable `tdata` until `tready`, then go to DATA.
- **DATA**
  - Combinational pass-through: `o_s2mm_wr_tdata` = `i_wr_data`.
  - `o_s2mm_wr_tvalid` = `i_wr_data_valid` while in DATA.
  - `o_wr_data_ready` = `i_s2mm_wr_tready` while in DATA.
  - Beat counter loads `(length+7)>>3` (21 bits) and decrements on each handshake.
  - `tlast` is high while the counter equals 1.
  - `tkeep` = 8'hFF on every beat except the last, where it is `(8'h01 << length[2:0]) - 1` (8'hFF when `length[2:0]` = 0).
  - Handshake with `tlast` goes to STS.
- **STS**
  - `o_s2mm_sts_tready` = 1; it is 0 in every other state.
  - Timeout counter cleared on entry.
  - On `i_s2mm_sts_tvalid`: latch `tdata` into `o_wr_sts`. Error = (sts[3:0] ≠ issued tag) OR sts[7]=0 OR |sts[6:4]. Go to DONE.
  - If the counter reaches `STS_TIMEOUT` with no status: error, `o_wr_sts` = 8'h00, go to DONE.
- **DONE:** `o_wr_data_finish` = 1 and `o_wr_err` valid for exactly one cycle, then go to IDLE.

## Timing
- **Reset values:** all outputs 0 (`o_wr_sts` 8'h00, tag 0), state IDLE.
- **Request/ack**
  - `o_wr_cmd_ack` is a registered pulse in the cycle after IDLE accepts, for both valid and rejected requests.
  - The requester drops `i_wr_cmd_req` on the edge after seeing ack.
  - A request is never re-accepted before the FSM returns to IDLE.
- **Latencies**
  - Accept to `o_s2mm_wr_cmd_tvalid`: 1 cycle.
  - Reject path, accept to finish: 1 cycle.
  - Status handshake to finish: 1 cycle.
- **Data path:** zero-latency combinational path user→S2MM. Backpressure in both directions is honoured every cycle, and valid may toggle freely.
- **Data outside DATA:** beats offered in other states are not consumed (ready 0).
- **Reset mid-transfer:** immediate return to IDLE, outputs cleared, tag restarts at 0. The DataMover must be reset concurrently at system level.
- **Length boundaries**
  - Maximum length 2^23−1 gives 2^20 beats, with last-beat `tkeep` 8'h7F.
  - Length 1–8 is a single beat with `tlast` on the first handshake.

## Structure
- Shared package `datamover_pkg` holds:
  - a packed struct for the 72-bit S2MM/MM2S command and its field constants (INCR, EOF);
  - status bit positions (OKAY=7, SLVERR=6, DECERR=5, INTERR=4, TAG=[3:0]);
  - the FSM state enum;
  - a `last_keep(len[2:0])` function.
- Single module, no sub-module.

## Test plan
- **Full burst:** addr 0x0000, len 2048 → command tdata[22:0]=2048, [63:32]=0, tag 0; 256 beats, all tkeep 8'hFF, tlast on beat 256. OKAY status 8'h80 → finish with err=0.
- **Partial last beat:** len 2035 → 255 beats, last tkeep 8'h07. Tag 1 on the second command; status tag mismatch 8'h80 → err=1, `o_wr_sts`=8'h80.
- **Rejected requests:** len 0, and separately addr 0x0004 → ack then finish+err in the next cycle, no `o_s2mm_wr_cmd_tvalid`.
- **Backpressure:** random `i_s2mm_wr_tready`/`i_wr_data_valid` on len 24 → exactly 3 beats transferred, data in order, tlast only on beat 3.
- **Status timeout:** `STS_TIMEOUT`=16 with no status → finish+err=1, `o_wr_sts`=8'h00.
- **Reset mid-DATA:** assert `rst_n`=0 after beat 5 of 32 → all outputs 0, IDLE. The next request carries tag 0.
